// File: rtl/log_fpmul_pkg.sv
// Shared types and sizing helpers for the byte-serial Mitchell-approximation FP multiplier.
// Optional IEEE special-value handling in the core is enabled by defining LOGMUL_SPECIALS_EN.
package log_fpmul_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      CALC = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam int FLAG_OVF = 1;
   localparam int FLAG_UNF = 0;

   function automatic int calc_w(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   function automatic int calc_nb(input int exp_w, input int man_w);
      return calc_w(exp_w, man_w) / 8;
   endfunction

   // A single-byte format still needs a 1-bit counter to stay synthesizable.
   function automatic int calc_cnt_w(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

endpackage

// File: rtl/log_fpmul_core.sv
// Combinational Mitchell-approximation multiply: add exponents, add mantissas, no correction term.
// Defining LOGMUL_SPECIALS_EN adds Inf/NaN handling; otherwise all-ones exponents saturate as overflow.
module log_fpmul_core
   import log_fpmul_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int BIAS  = 2**(EXP_W-1) - 1
) (
   input  logic [calc_w(EXP_W, MAN_W)-1:0] a,
   input  logic [calc_w(EXP_W, MAN_W)-1:0] b,
   output logic [calc_w(EXP_W, MAN_W)-1:0] r,
   output logic [1:0]                      flags
);

   localparam int W = calc_w(EXP_W, MAN_W);
   localparam logic [EXP_W-1:0]        EXP_ONES = '1;
   localparam logic signed [EXP_W+1:0] BIAS_E   = (EXP_W+2)'(BIAS);
   localparam logic signed [EXP_W+1:0] MAX_E    = {2'b00, EXP_ONES};

   logic                     sa, sb, sr;
   logic [EXP_W-1:0]         ea, eb;
   logic [MAN_W-1:0]         ma, mb;
   logic [MAN_W:0]           s;
   logic signed [EXP_W+1:0]  e;
   logic                     a_zero, b_zero;
`ifdef LOGMUL_SPECIALS_EN
   localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
   logic a_inf, b_inf, a_nan, b_nan;
`endif

   always_comb begin
      sa = a[W-1];
      sb = b[W-1];
      ea = a[W-2 -: EXP_W];
      eb = b[W-2 -: EXP_W];
      ma = a[MAN_W-1:0];
      mb = b[MAN_W-1:0];
      sr = sa ^ sb;
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      s = {1'b0, ma} + {1'b0, mb};
      // Mantissa carry bumps the exponent by one: log2(1+x) ~ x.
      e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E
          + $signed({{(EXP_W+1){1'b0}}, s[MAN_W]});
      r = {sr, e[EXP_W-1:0], s[MAN_W-1:0]};
      flags = 2'b00;
`ifdef LOGMUL_SPECIALS_EN
      a_inf = (ea == EXP_ONES) && (ma == '0);
      b_inf = (eb == EXP_ONES) && (mb == '0);
      a_nan = (ea == EXP_ONES) && (ma != '0);
      b_nan = (eb == EXP_ONES) && (mb != '0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         r = QNAN;
      end else if (a_inf || b_inf) begin
         r = {sr, EXP_ONES, {MAN_W{1'b0}}};
      end else
`endif
      if (a_zero || b_zero) begin
         r = {sr, {(W-1){1'b0}}};
      end else if (e >= MAX_E) begin
         r = {sr, EXP_ONES, {MAN_W{1'b0}}};
         flags[FLAG_OVF] = 1'b1;
      end else if (e[EXP_W+1] || (e == '0)) begin
         r = {sr, {(W-1){1'b0}}};
         flags[FLAG_UNF] = 1'b1;
      end
   end

endmodule

// File: rtl/log_fpmul_serial.sv
// Byte-serial wrapper: collects operands LSB byte first, computes in one cycle, streams the result.
// Special-value handling in the core is compiled in when LOGMUL_SPECIALS_EN is defined.
module log_fpmul_serial
   import log_fpmul_pkg::*;
#(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int BIAS  = 2**(EXP_W-1) - 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a_byte,
   input  logic [7:0] b_byte,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_byte,
   output logic [1:0] out_flags
);

   localparam int W  = calc_w(EXP_W, MAN_W);
   localparam int NB = calc_nb(EXP_W, MAN_W);
   localparam int CW = calc_cnt_w(NB);
   localparam logic [CW-1:0] LAST = CW'(NB - 1);

   state_t          state_reg, state_next;
   logic [CW-1:0]   beat_cnt_reg, k_reg;
   logic [W-1:0]    a_reg, b_reg, r_reg, r_core;
   logic [1:0]      flags_reg, flags_core;
   logic            in_fire, out_fire;
   logic [7:0]      r_bytes [NB];

   log_fpmul_core #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W),
      .BIAS  (BIAS)
   ) u_core (
      .a     (a_reg),
      .b     (b_reg),
      .r     (r_core),
      .flags (flags_core)
   );

   for (genvar gi = 0; gi < NB; gi++) begin : g_r_bytes
      assign r_bytes[gi] = r_reg[8*gi +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= LOAD;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = (state_reg == LOAD) && !rst;
      out_valid  = (state_reg == SEND);
      in_fire    = in_valid && in_ready;
      out_fire   = out_valid && out_ready;
      case (state_reg)
         LOAD:    if (in_fire && (beat_cnt_reg == LAST)) state_next = CALC;
         CALC:    state_next = SEND;
         SEND:    if (out_fire && (k_reg == LAST)) state_next = LOAD;
         default: state_next = LOAD;
      endcase
      out_byte  = out_valid ? r_bytes[k_reg] : 8'd0;
      out_flags = out_valid ? flags_reg : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_reg <= '0;
         k_reg        <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         r_reg        <= '0;
         flags_reg    <= '0;
      end else begin
         if (in_fire) begin
            beat_cnt_reg <= (beat_cnt_reg == LAST) ? '0 : beat_cnt_reg + 1'b1;
            for (int i = 0; i < NB; i++) begin
               if (beat_cnt_reg == CW'(i)) begin
                  a_reg[8*i +: 8] <= a_byte;
                  b_reg[8*i +: 8] <= b_byte;
               end
            end
         end
         if (state_reg == CALC) begin
            r_reg     <= r_core;
            flags_reg <= flags_core;
         end
         if (out_fire) k_reg <= (k_reg == LAST) ? '0 : k_reg + 1'b1;
      end
   end

endmodule

// File: doc/log_fpmul_serial.md
# log_fpmul_serial

Parametrised byte-serial logarithmic (Mitchell-approximation) floating-point multiplier. It generalises the fixed 16-bit, two-beat multiplier tile to any IEEE-style format whose total width is a multiple of 8, and adds valid/ready handshakes on both input and output, a byte-serial result stream and overflow/underflow flags. It sits between the pad-facing byte buses (operand A on one byte lane, operand B on the other) and the output byte lane of the Tiny Tapeout wrapper.

## Interface
- EXP_W, default 5: exponent field width.
- MAN_W, default 10: stored mantissa width. Total width W = 1+EXP_W+MAN_W must be a multiple of 8. NB = W/8.
- BIAS, default 2^(EXP_W-1)-1: exponent bias.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a_byte/b_byte hold a valid beat.
- in_ready  out  1  block accepts an input beat this cycle.
- a_byte  in  8  operand A byte, LSB byte first.
- b_byte  in  8  operand B byte, LSB byte first.
- out_valid  out  1  out_byte holds a valid result beat.
- out_ready  in  1  sink accepts the output beat.
- out_byte  out  8  result byte, LSB byte first.
- out_flags  out  2  {ovf, unf}; valid while out_valid is high, constant for the whole result.

## Operation
- FSM states: LOAD, CALC, SEND.
- LOAD: in_ready=1. Each in_valid&in_ready beat shifts a_byte and b_byte into the A and B registers at byte index beat_cnt, then increments beat_cnt. On beat NB-1, beat_cnt clears and the FSM moves to CALC.
- CALC: lasts one cycle. The core result and flags are registered, and the FSM moves to SEND. in_ready=0.
- SEND: out_valid=1 and out_byte = R[8*k +: 8]. Each out_valid&out_ready beat increments k. On beat NB-1, k clears and the FSM returns to LOAD. in_ready=0.
- Arithmetic, normal inputs:
  - Sign: sa^sb.
  - Mantissa sum: s = {0,ma}+{0,mb}, MAN_W+1 bits. c = s[MAN_W].
  - Result mantissa: s[MAN_W-1:0].
  - Exponent: e = ea+eb-BIAS+c, signed, EXP_W+2 bits.
- Zero or subnormal input (exponent field 0): result is signed zero. Flags are 0.
- e ≥ 2^EXP_W-1: result is signed infinity (exponent all ones, mantissa 0). ovf=1.
- e ≤ 0: result is signed zero. unf=1.
- Approximation error is intentional: no rounding, no correction term.

## Timing
- Reset values: in_ready=0 during reset, then 1 from the first cycle after reset deasserts. out_valid=0, out_byte=0, out_flags=0, state=LOAD, counters=0, operand registers=0.
- Latency: if the last input beat is accepted at edge t, out_valid rises after edge t+1 (CALC occupies t..t+1), carrying byte 0.
- Throughput: one result per 2·NB+1 cycles, with no stalls.
- in_valid low in LOAD: hold state and partial operands indefinitely.
- out_ready low in SEND: hold out_byte, out_flags and k stable.
- in_valid during CALC or SEND is ignored; no beat is consumed.
- rst asserted mid-load or mid-send: partial operands and the pending result are discarded. The next beat after reset is treated as byte 0.

## Configuration
- LOGMUL_SPECIALS_EN defined:
  - Exponent all ones is treated as Inf/NaN.
  - Any NaN input, or Inf×zero, gives canonical qNaN: sign 0, exponent all ones, mantissa MSB 1, other bits 0. Flags are 0.
  - Inf×nonzero gives signed Inf. Flags are 0.
  - These checks take priority over the zero/overflow rules.
- Not defined: all-ones exponents go through the normal arithmetic path, saturating via the overflow rule.

## Structure
- Package log_fpmul_pkg holds:
  - the state enum (LOAD, CALC, SEND);
  - localparam functions for W, NB and the counter width $clog2(NB);
  - the flag bit indices.
- Sub-module log_fpmul_core is purely combinational: A, B in; R, flags out. The serial FSM and shift registers stay in log_fpmul_serial.

## Test plan
- Default FP16, A=0x3E00 (1.5), B=0x4200 (3.0). Send bytes 00/00 then 3E/42 → out bytes 00, 44 (R=0x4400, approximates 4.5), flags 00. out_valid appears 2 cycles after the last accepted beat.
- A=0x4000, B=0x3D00 → R=0x4100. A=0xBC00, B=0x3C00 → R=0xBC00.
- A=0x7800, B=0x7800 → R=0x7C00, flags 10. A=0x0400, B=0x0400 → R=0x0000, flags 01. A=0x0000, B=0x4200 → R=0x0000, flags 00.
- Handshake: toggle in_valid every other cycle and hold out_ready low for 3 cycles mid-result → same result bytes, out_byte stable while stalled, no beats accepted in CALC or SEND.
- Reset after one input beat, then a full A=0x3C00, B=0x3C00 transaction → R=0x3C00.
- With LOGMUL_SPECIALS_EN: A=0x7C00, B=0x0000 → R=0x7E00. Without it: R=0x0000.
- Repeat the first scenario with EXP_W=8, MAN_W=7 (BF16): A=0x3FC0, B=0x4040 → R=0x4080.
